// File: rtl/rib_arbiter_pkg.sv
// Shared definitions for the RIB bus arbiter.
//   - HOLD_ENABLE / HOLD_DISABLE : encoding of the pipeline hold request
//   - RIB_MASTER_NUM / RIB_ID_W   : default master count and index width
//   - arb_state_e                 : arbiter state encoding
package rib_arbiter_pkg;

  localparam logic HOLD_ENABLE  = 1'b1;
  localparam logic HOLD_DISABLE = 1'b0;

  localparam int RIB_MASTER_NUM = 4;
  localparam int RIB_ID_W       = 2;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rib_arbiter_rr_pick.sv
// Combinational rotating priority encoder.
// Picks the lowest index at or after ptr_i (wrapping modulo N) whose request
// bit is set and whose mask bit is clear.
//   req_i    [N]    : request vector
//   ptr_i    [ID_W] : index with highest priority
//   mask_i   [N]    : bits excluded from this pick
//   valid_o         : some unmasked request exists
//   idx_o    [ID_W] : winning index (0 when !valid_o)
//   onehot_o [N]    : one-hot of the winner (0 when !valid_o)
module rib_arbiter_rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  input  logic [N-1:0]    mask_i,
  output logic            valid_o,
  output logic [ID_W-1:0] idx_o,
  output logic [N-1:0]    onehot_o
);

  logic [N-1:0] eff_req;

  assign eff_req = req_i & ~mask_i;

  // NOTE: every output of a combinational block is given a default first so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    int               j;
    logic [ID_W-1:0]  cand;
    j        = 0;
    cand     = '0;
    valid_o  = |eff_req;
    idx_o    = '0;
    onehot_o = '0;
    // Walk from the farthest offset back to the pointer so the candidate
    // closest to the pointer is the last one written and therefore wins.
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      cand = ID_W'(j);
      if (eff_req[cand]) idx_o = cand;
    end
    if (valid_o) onehot_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/rib_arbiter.sv
// Round-robin arbiter sharing the RIB slave port between bus masters.
// A grant is held until ack_i or a timeout; on release the next master is
// picked in the same cycle so back-to-back grants have no dead cycle.
//   clk         : system clock
//   rst         : synchronous active-high reset
//   req_i       : per-master request, held until its transaction completes
//   ack_i       : slave transaction-complete strobe
//   grant_o     : registered one-hot grant, zero when idle
//   grant_id_o  : index of the granted master, zero when idle
//   busy_o      : a grant is active
//   err_o       : one-cycle pulse when a grant is released by timeout
//   err_id_o    : master that last timed out
//   hold_flag_o : pipeline hold while the core master waits for the bus
module rib_arbiter
  import rib_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = RIB_MASTER_NUM,
  parameter int CORE_MASTER    = 0,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int ID_W           = RIB_ID_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic                   ack_i,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic [ID_W-1:0]        grant_id_o,
  output logic                   busy_o,
  output logic                   err_o,
  output logic [ID_W-1:0]        err_id_o,
  output logic                   hold_flag_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(TIMEOUT_CYCLES);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [ID_W-1:0]        grant_id_q, grant_id_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [ID_W-1:0]        err_id_q, err_id_d;

  logic                   timeout_hit;
  logic                   release_now;
  logic [ID_W-1:0]        next_ptr;
  logic [ID_W-1:0]        pick_ptr;
  logic [NUM_MASTERS-1:0] pick_mask;
  logic                   pick_valid;
  logic [ID_W-1:0]        pick_idx;
  logic [NUM_MASTERS-1:0] pick_onehot;

  // ack has priority: a timeout on the ack cycle is not an error.
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (state_q == ARB_BUSY) &&
                       !ack_i && (cnt_q == CNT_LAST);
  assign release_now = (state_q == ARB_BUSY) && (ack_i || timeout_hit);

  assign next_ptr = (grant_id_q == ID_W'(NUM_MASTERS - 1)) ? '0
                                                           : grant_id_q + ID_W'(1);

  // While busy the picker looks ahead as if the grant were released now, so
  // the releasing master is excluded and the search starts just after it.
  assign pick_ptr  = (state_q == ARB_BUSY) ? next_ptr : ptr_q;
  assign pick_mask = (state_q == ARB_BUSY) ? grant_q : '0;

  rib_arbiter_rr_pick #(
    .N    (NUM_MASTERS),
    .ID_W (ID_W)
  ) u_rr_pick (
    .req_i    (req_i),
    .ptr_i    (pick_ptr),
    .mask_i   (pick_mask),
    .valid_o  (pick_valid),
    .idx_o    (pick_idx),
    .onehot_o (pick_onehot)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    err_id_d   = err_id_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d    = ARB_BUSY;
          grant_d    = pick_onehot;
          grant_id_d = pick_idx;
          cnt_d      = '0;
        end
      end
      ARB_BUSY: begin
        if (release_now) begin
          ptr_d = next_ptr;
          cnt_d = '0;
          if (timeout_hit) begin
            err_d    = 1'b1;
            err_id_d = grant_id_q;
          end
          if (pick_valid) begin
            grant_d    = pick_onehot;
            grant_id_d = pick_idx;
          end else begin
            state_d    = ARB_IDLE;
            grant_d    = '0;
            grant_id_d = '0;
          end
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_id_q   <= err_id_d;
    end
  end

  assign grant_o    = grant_q;
  assign grant_id_o = grant_id_q;
  assign busy_o     = (state_q == ARB_BUSY);
  assign err_o      = err_q;
  assign err_id_o   = err_id_q;

  // Gated by rst so the pipeline is not held while the arbiter is in reset.
  assign hold_flag_o = rst ? HOLD_DISABLE
                           : (req_i[CORE_MASTER] & ~grant_q[CORE_MASTER]);

endmodule

// File: tb/tb_rib_arbiter.sv
// Directed self-checking bench for rib_arbiter (4 masters, core master 0,
// timeout 8). Each step drives inputs, pushes the outputs expected after the
// next rising edge onto a scoreboard queue, then pops and compares at edge+1.
module tb_rib_arbiter;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] id;
    logic       busy;
    logic       err;
    logic [1:0] err_id;
    logic       hold;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       ack;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       err;
  logic [1:0] err_id;
  logic       hold_flag;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  rib_arbiter #(
    .NUM_MASTERS    (4),
    .CORE_MASTER    (0),
    .TIMEOUT_CYCLES (8),
    .ID_W           (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .ack_i       (ack),
    .grant_o     (grant),
    .grant_id_o  (grant_id),
    .busy_o      (busy),
    .err_o       (err),
    .err_id_o    (err_id),
    .hold_flag_o (hold_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs, queue the expected post-edge outputs, advance one edge,
  // then pop the scoreboard and compare every output.
  task automatic step(input string tag,
                      input logic r, input logic [3:0] rq, input logic a,
                      input logic [3:0] e_grant, input logic [1:0] e_id,
                      input logic e_busy, input logic e_err,
                      input logic [1:0] e_err_id, input logic e_hold);
    exp_t e;
    rst = r;
    req = rq;
    ack = a;
    sb_q.push_back('{grant: e_grant, id: e_id, busy: e_busy, err: e_err,
                     err_id: e_err_id, hold: e_hold});
    @(posedge clk);
    #1;
    checks++;
    assert (sb_q.size() != 0) else begin
      errors++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, ".grant"},    {4'h0, grant},    {4'h0, e.grant});
      check({tag, ".grant_id"}, {6'h0, grant_id}, {6'h0, e.id});
      check({tag, ".busy"},     {7'h0, busy},     {7'h0, e.busy});
      check({tag, ".err"},      {7'h0, err},      {7'h0, e.err});
      check({tag, ".err_id"},   {6'h0, err_id},   {6'h0, e.err_id});
      check({tag, ".hold"},     {7'h0, hold_flag}, {7'h0, e.hold});
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b1111;
    ack = 1'b0;

    // 1. reset with all requesting, then first grant goes to master 0
    //    tag           rst req      ack grant    id  bsy err eid hold
    step("rst_a",       1, 4'b1111, 0, 4'b0000, 0, 0, 0, 0, 0);
    step("rst_b",       1, 4'b1111, 0, 4'b0000, 0, 0, 0, 0, 0);
    step("rst_c",       1, 4'b1111, 0, 4'b0000, 0, 0, 0, 0, 0);
    step("first_grant", 0, 4'b1111, 0, 4'b0001, 0, 1, 0, 0, 0);
    step("rel_idle0",   0, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0);

    // 2. single requester 2; its early req drop is ignored; ack -> idle
    step("single_gnt",  0, 4'b0100, 0, 4'b0100, 2, 1, 0, 0, 0);
    step("single_drop", 0, 4'b0000, 0, 4'b0100, 2, 1, 0, 0, 0);
    step("single_hold", 0, 4'b0000, 0, 4'b0100, 2, 1, 0, 0, 0);
    step("single_ack",  0, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0);

    // 3. pointer now at 3; all requesting, ack every 2nd cycle
    step("rr_3",        0, 4'b1111, 0, 4'b1000, 3, 1, 0, 0, 1);
    step("rr_3h",       0, 4'b1111, 0, 4'b1000, 3, 1, 0, 0, 1);
    step("rr_0",        0, 4'b1111, 1, 4'b0001, 0, 1, 0, 0, 0);
    step("rr_0h",       0, 4'b1111, 0, 4'b0001, 0, 1, 0, 0, 0);
    step("rr_1",        0, 4'b1111, 1, 4'b0010, 1, 1, 0, 0, 1);
    step("rr_1h",       0, 4'b1111, 0, 4'b0010, 1, 1, 0, 0, 1);
    step("rr_2",        0, 4'b1111, 1, 4'b0100, 2, 1, 0, 0, 1);
    step("rr_2h",       0, 4'b1111, 0, 4'b0100, 2, 1, 0, 0, 1);
    step("rr_3b",       0, 4'b1111, 1, 4'b1000, 3, 1, 0, 0, 1);
    step("rr_3bh",      0, 4'b1111, 0, 4'b1000, 3, 1, 0, 0, 1);
    step("rr_0b",       0, 4'b1111, 1, 4'b0001, 0, 1, 0, 0, 0);

    // 4. master 2 holds the bus while core master 0 waits
    step("hold_g2",     0, 4'b0100, 1, 4'b0100, 2, 1, 0, 0, 0);
    step("hold_on_a",   0, 4'b0101, 0, 4'b0100, 2, 1, 0, 0, 1);
    step("hold_on_b",   0, 4'b0101, 0, 4'b0100, 2, 1, 0, 0, 1);
    step("hold_off",    0, 4'b0101, 1, 4'b0001, 0, 1, 0, 0, 0);
    step("hold_idle",   0, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0);

    // 5a. master 1 granted, no ack: 8th busy cycle releases with err pulse
    step("to_gnt",      0, 4'b1010, 0, 4'b0010, 1, 1, 0, 0, 0);
    for (int i = 1; i <= 7; i++)
      step("to_wait",   0, 4'b1010, 0, 4'b0010, 1, 1, 0, 0, 0);
    step("to_err",      0, 4'b1010, 0, 4'b1000, 3, 1, 1, 1, 0);
    step("to_err_end",  0, 4'b1010, 0, 4'b1000, 3, 1, 0, 1, 0);

    // 5b. master 3 reaches the timeout cycle but acks on it: no err pulse
    for (int i = 2; i <= 7; i++)
      step("ta_wait",   0, 4'b1010, 0, 4'b1000, 3, 1, 0, 1, 0);
    step("ta_ack",      0, 4'b1010, 1, 4'b0010, 1, 1, 0, 1, 0);
    step("ta_after",    0, 4'b1010, 0, 4'b0010, 1, 1, 0, 1, 0);

    // 6. master 3 granted, reset together with ack: everything clears
    step("mr_g3",       0, 4'b1000, 1, 4'b1000, 3, 1, 0, 1, 0);
    step("mr_rst",      1, 4'b1000, 1, 4'b0000, 0, 0, 0, 0, 0);
    step("idle_ack",    0, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0);
    step("mr_ptr0",     0, 4'b1111, 0, 4'b0001, 0, 1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
